// File: rtl/watch_pkg.sv
// Shared constants for the watch time-set path: field moduli,
// field encodings, FSM state codes and the state-to-field map.
package watch_pkg;

  localparam int C_SEC_MOD  = 60;
  localparam int C_MIN_MOD  = 60;
  localparam int C_HOUR_MOD = 24;
  localparam int C_DAY_MOD  = 365;

  localparam logic [1:0] F_HOUR = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_SEC  = 2'd2;
  localparam logic [1:0] F_DAY  = 2'd3;

  localparam logic [2:0] S_RUN      = 3'd0;
  localparam logic [2:0] S_SET_HOUR = 3'd1;
  localparam logic [2:0] S_SET_MIN  = 3'd2;
  localparam logic [2:0] S_SET_SEC  = 3'd3;
  localparam logic [2:0] S_SET_DAY  = 3'd4;
  localparam logic [2:0] S_COMMIT   = 3'd5;

  function automatic logic [1:0] field_of(
    input logic [2:0] s
  );
    logic [1:0] f;
    f = F_HOUR;
    case (s)
      S_SET_MIN: f = F_MIN;
      S_SET_SEC: f = F_SEC;
      S_SET_DAY: f = F_DAY;
      default:   f = F_HOUR;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/watch_field_step.sv
// Combinational modulo step for one time field.
// Ports: val (current), up/down (step request), nxt (stepped value).
module watch_field_step #(
  parameter int W   = 6,
  parameter int MOD = 60
) (
  input  logic [W-1:0] val,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  // up and down together cancel out
  always_comb begin
    nxt = val;
    if (up && !down) begin
      nxt = (val >= MAX) ? '0 : val + 1'b1;
    end else if (down && !up) begin
      nxt = (val == '0 || val > MAX) ? MAX : val - 1'b1;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set controller: capture live time, edit fields, commit via load.
// Ports: buttons i_*, live time i_*, run enable, load strobe, edit regs, field, busy.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int P_SEC_BIT     = 6,
  parameter int P_MIN_BIT     = 6,
  parameter int P_HOUR_BIT    = 5,
  parameter int P_DAY_BIT     = 9,
  parameter int P_TIMEOUT_BIT = 30,
  parameter logic [P_TIMEOUT_BIT-1:0] P_TIMEOUT_CYC = 30'd1000000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_mode,
  input  logic                  i_up,
  input  logic                  i_down,
  input  logic                  i_cancel,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic [P_DAY_BIT-1:0]  i_day,
  output logic                  o_run_en,
  output logic                  o_load,
  output logic [P_SEC_BIT-1:0]  o_set_sec,
  output logic [P_MIN_BIT-1:0]  o_set_min,
  output logic [P_HOUR_BIT-1:0] o_set_hour,
  output logic [P_DAY_BIT-1:0]  o_set_day,
  output logic [1:0]            o_field,
  output logic                  o_busy
);

  localparam logic [P_TIMEOUT_BIT-1:0] TMO_LAST =
    P_TIMEOUT_CYC - 1'b1;

  localparam logic [P_SEC_BIT-1:0]  SMAX = P_SEC_BIT'(C_SEC_MOD - 1);
  localparam logic [P_MIN_BIT-1:0]  MMAX = P_MIN_BIT'(C_MIN_MOD - 1);
  localparam logic [P_HOUR_BIT-1:0] HMAX = P_HOUR_BIT'(C_HOUR_MOD - 1);
  localparam logic [P_DAY_BIT-1:0]  DMAX = P_DAY_BIT'(C_DAY_MOD - 1);

  logic [2:0]               state;
  logic [2:0]               nxt;
  logic [P_TIMEOUT_BIT-1:0] cnt;

  logic in_set;
  logic tmo;
  logic edit_ok;

  logic [P_SEC_BIT-1:0]  sec_step;
  logic [P_MIN_BIT-1:0]  min_step;
  logic [P_HOUR_BIT-1:0] hour_step;
  logic [P_DAY_BIT-1:0]  day_step;

  assign in_set = (state == S_SET_HOUR) || (state == S_SET_MIN) ||
                  (state == S_SET_SEC)  || (state == S_SET_DAY);
  assign tmo    = in_set && (cnt == TMO_LAST);
  // field edits lose to cancel, timeout and mode
  assign edit_ok = in_set && !i_cancel && !tmo && !i_mode;

  always_comb begin
    nxt = state;
    case (state)
      S_RUN:      if (i_mode) nxt = S_SET_HOUR;
      S_COMMIT:   nxt = S_RUN;
      S_SET_HOUR,
      S_SET_MIN,
      S_SET_SEC,
      S_SET_DAY: begin
        if (i_cancel || tmo) begin
          nxt = S_RUN;
        end else if (i_mode) begin
          case (state)
            S_SET_HOUR: nxt = S_SET_MIN;
            S_SET_MIN:  nxt = S_SET_SEC;
            S_SET_SEC:  nxt = S_SET_DAY;
            default:    nxt = S_COMMIT;
          endcase
        end
      end
      default:    nxt = S_RUN;
    endcase
  end

  watch_field_step #(.W(P_HOUR_BIT), .MOD(C_HOUR_MOD)) u_hour (
    .val  (o_set_hour),
    .up   (edit_ok && state == S_SET_HOUR && i_up),
    .down (edit_ok && state == S_SET_HOUR && i_down),
    .nxt  (hour_step)
  );

  watch_field_step #(.W(P_MIN_BIT), .MOD(C_MIN_MOD)) u_min (
    .val  (o_set_min),
    .up   (edit_ok && state == S_SET_MIN && i_up),
    .down (edit_ok && state == S_SET_MIN && i_down),
    .nxt  (min_step)
  );

  watch_field_step #(.W(P_SEC_BIT), .MOD(C_SEC_MOD)) u_sec (
    .val  (o_set_sec),
    .up   (edit_ok && state == S_SET_SEC && i_up),
    .down (edit_ok && state == S_SET_SEC && i_down),
    .nxt  (sec_step)
  );

  watch_field_step #(.W(P_DAY_BIT), .MOD(C_DAY_MOD)) u_day (
    .val  (o_set_day),
    .up   (edit_ok && state == S_SET_DAY && i_up),
    .down (edit_ok && state == S_SET_DAY && i_down),
    .nxt  (day_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_RUN;
      cnt        <= '0;
      o_run_en   <= 1'b1;
      o_load     <= 1'b0;
      o_busy     <= 1'b0;
      o_field    <= F_HOUR;
      o_set_sec  <= '0;
      o_set_min  <= '0;
      o_set_hour <= '0;
      o_set_day  <= '0;
    end else begin
      state    <= nxt;
      // any button activity restarts the idle count
      cnt      <= (edit_ok && !(i_up || i_down)) ? cnt + 1'b1 : '0;
      o_run_en <= (nxt == S_RUN);
      o_busy   <= (nxt != S_RUN);
      o_load   <= (nxt == S_COMMIT);
      o_field  <= field_of(nxt);
      if (state == S_RUN && i_mode) begin
        o_set_hour <= (i_hour > HMAX) ? HMAX : i_hour;
        o_set_min  <= (i_min  > MMAX) ? MMAX : i_min;
        o_set_sec  <= (i_sec  > SMAX) ? SMAX : i_sec;
        o_set_day  <= (i_day  > DMAX) ? DMAX : i_day;
      end else if (edit_ok) begin
        o_set_hour <= hour_step;
        o_set_min  <= min_step;
        o_set_sec  <= sec_step;
        o_set_day  <= day_step;
      end
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed self-checking bench for watch_set_ctrl.
// Short idle timeout so the auto-abort path fits in a few cycles.
module tb_watch_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_mode, i_up, i_down, i_cancel;
  logic [5:0] i_sec, i_min;
  logic [4:0] i_hour;
  logic [8:0] i_day;
  logic       o_run_en, o_load, o_busy;
  logic [5:0] o_set_sec, o_set_min;
  logic [4:0] o_set_hour;
  logic [8:0] o_set_day;
  logic [1:0] o_field;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;

  watch_set_ctrl #(
    .P_TIMEOUT_CYC(30'd16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_mode     (i_mode),
    .i_up       (i_up),
    .i_down     (i_down),
    .i_cancel   (i_cancel),
    .i_sec      (i_sec),
    .i_min      (i_min),
    .i_hour     (i_hour),
    .i_day      (i_day),
    .o_run_en   (o_run_en),
    .o_load     (o_load),
    .o_set_sec  (o_set_sec),
    .o_set_min  (o_set_min),
    .o_set_hour (o_set_hour),
    .o_set_day  (o_set_day),
    .o_field    (o_field),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_load === 1'b1) load_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic live(input int h, input int m, input int s, input int d);
    i_hour = 5'(h);
    i_min  = 6'(m);
    i_sec  = 6'(s);
    i_day  = 9'(d);
  endtask

  // drive buttons for one clock edge, return 1ns after that edge
  task automatic pulse(input logic m, input logic u,
                       input logic d, input logic c);
    @(negedge clk);
    i_mode = m; i_up = u; i_down = d; i_cancel = c;
    @(posedge clk);
    #1;
    i_mode = 0; i_up = 0; i_down = 0; i_cancel = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lc;
    reset = 1'b0;
    i_mode = 0; i_up = 0; i_down = 0; i_cancel = 0;
    live(5, 30, 12, 7);
    #12;
    chk("rst_run_en", o_run_en, 1);
    chk("rst_load", o_load, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_field", o_field, 0);
    chk("rst_set", {o_set_hour, o_set_min, o_set_sec, o_set_day}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("idle_run_en", o_run_en, 1);
    chk("idle_busy", o_busy, 0);

    // full edit pass commits captured time
    pulse(1, 0, 0, 0);
    live(1, 2, 3, 4);
    chk("enter_run_en", o_run_en, 0);
    chk("enter_busy", o_busy, 1);
    chk("enter_field", o_field, 0);
    chk("cap_hour", o_set_hour, 5);
    chk("cap_min", o_set_min, 30);
    chk("cap_sec", o_set_sec, 12);
    chk("cap_day", o_set_day, 7);
    pulse(1, 0, 0, 0);
    chk("field_min", o_field, 1);
    pulse(1, 0, 0, 0);
    chk("field_sec", o_field, 2);
    pulse(1, 0, 0, 0);
    chk("field_day", o_field, 3);
    chk("pre_commit_load", o_load, 0);
    pulse(1, 0, 0, 0);
    chk("commit_load", o_load, 1);
    chk("commit_run_en", o_run_en, 0);
    chk("commit_hour", o_set_hour, 5);
    chk("commit_min", o_set_min, 30);
    chk("commit_sec", o_set_sec, 12);
    chk("commit_day", o_set_day, 7);
    step();
    chk("post_load", o_load, 0);
    chk("post_run_en", o_run_en, 1);
    chk("post_busy", o_busy, 0);
    step();
    chk("load_once", load_cnt, 1);

    // wrap boundaries
    live(23, 0, 59, 364);
    pulse(1, 0, 0, 0);
    chk("cap_h23", o_set_hour, 23);
    pulse(0, 1, 0, 0);
    chk("hour_up_wrap", o_set_hour, 0);
    pulse(0, 0, 1, 0);
    chk("hour_dn_wrap", o_set_hour, 23);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("min_dn_wrap", o_set_min, 59);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("sec_up_wrap", o_set_sec, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("day_up_wrap", o_set_day, 0);
    pulse(0, 0, 1, 0);
    chk("day_dn_wrap", o_set_day, 364);
    pulse(0, 1, 1, 0);
    chk("up_dn_hold", o_set_day, 364);
    chk("other_hold", o_set_hour, 23);
    pulse(0, 0, 0, 1);
    chk("cancel_run_en", o_run_en, 1);
    chk("cancel_busy", o_busy, 0);
    chk("cancel_keep", o_set_day, 364);
    step();
    chk("cancel_noload", load_cnt, 1);

    // priority: mode over up, cancel over mode; clamp on capture
    live(10, 20, 30, 100);
    pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    chk("mode_up_field", o_field, 1);
    chk("mode_up_hour", o_set_hour, 10);
    chk("mode_up_min", o_set_min, 20);
    pulse(1, 0, 0, 1);
    chk("cancel_mode_run", o_run_en, 1);
    chk("cancel_mode_busy", o_busy, 0);
    step();
    chk("cancel_mode_noload", load_cnt, 1);
    live(31, 63, 60, 400);
    pulse(1, 0, 0, 0);
    chk("clamp_hour", o_set_hour, 23);
    chk("clamp_min", o_set_min, 59);
    chk("clamp_sec", o_set_sec, 59);
    chk("clamp_day", o_set_day, 364);
    pulse(0, 0, 0, 1);

    // idle timeout
    live(10, 20, 30, 100);
    pulse(1, 0, 0, 0);
    for (int k = 0; k < 15; k++) step();
    chk("tmo_busy15", o_busy, 1);
    step();
    chk("tmo_run16", o_run_en, 1);
    chk("tmo_busy16", o_busy, 0);
    step();
    chk("tmo_noload", load_cnt, 1);

    // up at cycle 10 restarts the idle count
    pulse(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) step();
    pulse(0, 1, 0, 0);
    chk("restart_hour", o_set_hour, 11);
    for (int k = 0; k < 15; k++) step();
    chk("restart_busy", o_busy, 1);
    step();
    chk("restart_run", o_run_en, 1);

    // async reset in the middle of an edit
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    chk("edit_min", o_set_min, 19);
    chk("edit_field", o_field, 1);
    lc = load_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_run_en", o_run_en, 1);
    chk("arst_busy", o_busy, 0);
    chk("arst_field", o_field, 0);
    chk("arst_set", {o_set_hour, o_set_min, o_set_sec, o_set_day}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    chk("arst_post_run", o_run_en, 1);
    chk("arst_noload", load_cnt, lc);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
